// File: rtl/instruction_fetch_control.sv
// Multicycle RV32-subset control: instruction register, Moore FSM and retired counter.
// Drives the instruction word and immediate format select into the immediate extender.
module instruction_fetch_control #(
   parameter logic [31:0] RESET_INSTR = 32'h00000013,
   parameter int          COUNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            memory_data_in,
   input  logic                   mem_ready,
   output logic [31:0]            full_instruction,
   output logic [1:0]             immediate_source,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   address_source,
   output logic                   ir_write,
   output logic                   pc_write,
   output logic                   reg_write,
   output logic [1:0]             alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             alu_op,
   output logic [1:0]             result_source,
   output logic                   illegal_instr,
   output logic [COUNT_WIDTH-1:0] retired_count
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, JAL, LUI, ILLEGAL
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            ir_q, ir_d;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;
   logic [6:0]             opcode;
   logic [1:0]             imm_op;
   logic                   retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ir_q      <= RESET_INSTR;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   assign opcode           = ir_q[6:0];
   assign full_instruction = ir_q;
   assign retired_count    = retired_q;

   always_comb begin
      imm_op = 2'b00;
      case (opcode)
         OP_SW:          imm_op = 2'b01;
         OP_JAL, OP_LUI: imm_op = 2'b10;
         default:        imm_op = 2'b00;
      endcase
   end

   always_comb begin
      state_d          = state_q;
      ir_d             = ir_q;
      retire           = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      address_source   = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      alu_src_a        = 2'b00;
      alu_src_b        = 2'b00;
      alu_op           = 2'b00;
      result_source    = 2'b00;
      illegal_instr    = 1'b0;
      // Constant-1 select outside decode keeps the extender toggling on every new IR.
      immediate_source = (state_q == IDLE || state_q == FETCH) ? 2'b11 : imm_op;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               ir_d     = memory_data_in;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_I:         state_d = EXECUTEI;
               OP_JAL:       state_d = JAL;
               OP_LUI:       state_d = LUI;
               default:      state_d = ILLEGAL;
            endcase
         end
         MEMADR: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_read       = 1'b1;
            address_source = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            reg_write     = 1'b1;
            result_source = 2'b01;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         MEMWRITE: begin
            mem_write      = 1'b1;
            address_source = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXECUTER: begin
            alu_src_a = 2'b01;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         EXECUTEI: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         JAL: begin
            alu_src_a     = 2'b10;
            alu_src_b     = 2'b01;
            pc_write      = 1'b1;
            reg_write     = 1'b1;
            result_source = 2'b10;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         LUI: begin
            reg_write     = 1'b1;
            result_source = 2'b11;
            retire        = 1'b1;
            state_d       = FETCH;
         end
         ILLEGAL: begin
            illegal_instr = 1'b1;
            state_d       = FETCH;
         end
         default: state_d = IDLE;
      endcase
      retired_d = retire ? retired_q + COUNT_WIDTH'(1) : retired_q;
   end

endmodule

// File: tb/tb_instruction_fetch_control.sv
// Bench for instruction_fetch_control: directed instructions, randomized instruction stream
// with random memory wait states, and an asynchronous reset during a load wait.
module tb_instruction_fetch_control;

   logic        clk, reset, mem_ready;
   logic [31:0] memory_data_in, full_instruction, retired_count;
   logic [1:0]  immediate_source, alu_src_a, alu_src_b, alu_op, result_source;
   logic        mem_read, mem_write, address_source, ir_write, pc_write, reg_write, illegal_instr;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ir;
   logic [31:0] exp_count;
   logic [16:0] act;

   instruction_fetch_control dut (
      .clk(clk), .reset(reset), .memory_data_in(memory_data_in), .mem_ready(mem_ready),
      .full_instruction(full_instruction), .immediate_source(immediate_source),
      .mem_read(mem_read), .mem_write(mem_write), .address_source(address_source),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_source(result_source), .illegal_instr(illegal_instr),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act = {mem_read, mem_write, address_source, ir_write, pc_write, reg_write, illegal_instr,
                 alu_src_a, alu_src_b, alu_op, result_source, immediate_source};

   // Expected control word: mr mw as irw pcw rw ill | a b op rs imm
   function automatic logic [16:0] cv(input logic mr, input logic mw, input logic as,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic ill, input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic [1:0] rs,
                                      input logic [1:0] imm);
      return {mr, mw, as, irw, pcw, rw, ill, a, b, op, rs, imm};
   endfunction

   function automatic logic [1:0] imm_of(input logic [31:0] instr);
      case (instr[6:0])
         7'h23:        return 2'b01;
         7'h6F, 7'h37: return 2'b10;
         default:      return 2'b00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [16:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_bad++;
         $error("FAIL %s ctrl got %h expected %h", tag, act, exp);
      end
      n_cmp++;
      assert (full_instruction === exp_ir) else begin
         n_bad++;
         $error("FAIL %s ir got %h expected %h", tag, full_instruction, exp_ir);
      end
      n_cmp++;
      assert (retired_count === exp_count) else begin
         n_bad++;
         $error("FAIL %s retired got %0d expected %0d", tag, retired_count, exp_count);
      end
   endtask

   // One clock: drive in the low phase, check, then let the rising edge happen.
   task automatic step(input string tag, input logic rdy, input logic [31:0] din,
                       input logic [16:0] exp);
      @(negedge clk);
      mem_ready      = rdy;
      memory_data_in = din;
      #1;
      check(tag, exp);
      @(posedge clk);
   endtask

   task automatic run_instr(input logic [31:0] instr, input int fetch_waits, input int mem_waits);
      logic [1:0] im;
      im = imm_of(instr);
      for (int i = 0; i < fetch_waits; i++)
         step("fetch_wait", 1'b0, $urandom, cv(1,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b11));
      step("fetch", 1'b1, instr, cv(1,0,0,1,1,0,0, 2'b00,2'b01,2'b00,2'b00,2'b11));
      exp_ir = instr;
      step("decode", 1'($urandom), $urandom, cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,im));
      case (instr[6:0])
         7'h03: begin
            step("memadr", 1'($urandom), $urandom, cv(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,im));
            for (int i = 0; i < mem_waits; i++)
               step("memread_wait", 1'b0, $urandom, cv(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,im));
            step("memread", 1'b1, $urandom, cv(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,im));
            step("memwb", 1'($urandom), $urandom, cv(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01,im));
            exp_count++;
         end
         7'h23: begin
            step("memadr", 1'($urandom), $urandom, cv(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,im));
            for (int i = 0; i < mem_waits; i++)
               step("memwrite_wait", 1'b0, $urandom, cv(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,im));
            step("memwrite", 1'b1, $urandom, cv(0,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,im));
            exp_count++;
         end
         7'h33, 7'h13: begin
            if (instr[6:0] == 7'h33)
               step("execr", 1'($urandom), $urandom, cv(0,0,0,0,0,0,0, 2'b01,2'b00,2'b10,2'b00,im));
            else
               step("execi", 1'($urandom), $urandom, cv(0,0,0,0,0,0,0, 2'b01,2'b01,2'b10,2'b00,im));
            step("aluwb", 1'($urandom), $urandom, cv(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,im));
            exp_count++;
         end
         7'h6F: begin
            step("jal", 1'($urandom), $urandom, cv(0,0,0,0,1,1,0, 2'b10,2'b01,2'b00,2'b10,im));
            exp_count++;
         end
         7'h37: begin
            step("lui", 1'($urandom), $urandom, cv(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b11,im));
            exp_count++;
         end
         default:
            step("illegal", 1'($urandom), $urandom, cv(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,im));
      endcase
   endtask

   initial begin
      logic [6:0] ops [10];
      logic [31:0] instr;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h37, 7'h7F, 7'h63, 7'h67, 7'h00};
      reset = 1'b1;
      mem_ready = 1'b0;
      memory_data_in = 32'h0;
      exp_ir = 32'h00000013;
      exp_count = 32'd0;
      #3;
      check("reset", cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11));
      @(posedge clk);
      #1 reset = 1'b0;
      step("idle", 1'b1, 32'hDEADBEEF, cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11));

      run_instr(32'h00412083, 0, 0);
      run_instr(32'h00112223, 0, 3);
      run_instr(32'h008000EF, 0, 0);
      run_instr(32'h123450B7, 0, 0);
      run_instr(32'h0000007F, 0, 0);

      for (int n = 0; n < 200; n++) begin
         instr = {$urandom} & 32'hFFFF_FF80;
         instr[6:0] = ops[$urandom_range(0, 9)];
         run_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Asynchronous reset while a load waits on memory.
      step("fetch", 1'b1, 32'h00412083, cv(1,0,0,1,1,0,0, 2'b00,2'b01,2'b00,2'b00,2'b11));
      exp_ir = 32'h00412083;
      step("decode", 1'b0, 32'h0, cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
      step("memadr", 1'b0, 32'h0, cv(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00,2'b00));
      step("memread_wait", 1'b0, 32'h0, cv(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00));
      @(negedge clk);
      mem_ready = 1'b0;
      #2 reset = 1'b1;
      exp_ir = 32'h00000013;
      exp_count = 32'd0;
      #1;
      check("async_reset", cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11));
      @(posedge clk);
      #1 reset = 1'b0;
      step("idle_after_reset", 1'b1, 32'h0, cv(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b11));
      step("fetch_after_reset", 1'b0, 32'h0, cv(1,0,0,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b11));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_control.md
Name: instruction_fetch_control

Overview:
- Multicycle control stage directly upstream of the immediate extender.
- Holds the instruction register and drives `full_instruction` and `immediate_source` into the extender.
- A Moore FSM sequences fetch, decode, execute, memory and writeback for a word-addressed RV32 subset: lw, sw, R-type ALU, I-type ALU, jal, lui.
- Supports a ready handshake for variable-latency memory.

Parameters:
- RESET_INSTR, 32'h00000013, instruction-register value at reset (addi x0,x0,0).
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- memory_data_in  input  32  read data from unified memory
- mem_ready  input  1  memory completes the current read/write this cycle
- full_instruction  output  32  instruction register contents
- immediate_source  output  2  immediate format select: 00 I, 01 S, 10 upper-20 (lui/jal), 11 constant 1
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- address_source  output  1  0 = PC, 1 = ALU result
- ir_write  output  1  load instruction register
- pc_write  output  1  load PC
- reg_write  output  1  register-file write enable
- alu_src_a  output  2  00 PC, 01 rs1, 10 old PC
- alu_src_b  output  2  00 rs2, 01 immediate, 10 zero
- alu_op  output  2  00 add, 10 funct-decoded
- result_source  output  2  00 ALU result, 01 memory data, 10 PC+1, 11 immediate
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode
- retired_count  output  COUNT_WIDTH  count of completed legal instructions

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; IR = RESET_INSTR; retired_count = 0.
  - All strobes 0, all selects 00, immediate_source = 11.
- Outputs are decoded from the state register and IR opcode (IR[6:0]). Unlisted outputs are 0/00 in each state.
- IDLE: outputs as at reset; next state FETCH unconditionally.
- FETCH:
  - Drive mem_read=1, address_source=0, alu_src_a=00, alu_src_b=01, immediate_source=11, alu_op=00, so the ALU computes PC+1.
  - Hold while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, IR <= memory_data_in at the clock edge, then go to DECODE.
- immediate_source in every non-FETCH state comes from the IR opcode:
  - 0000011 lw and 0010011 I-ALU: 00
  - 0100011 sw: 01
  - 1101111 jal and 0110111 lui: 10
  - anything else: 00
  - This guarantees immediate_source changes after every IR load, so the extender re-evaluates for each new instruction.
- DECODE, dispatch on opcode:
  - lw/sw -> MEMADR
  - 0110011 -> EXECUTER
  - I-ALU -> EXECUTEI
  - jal -> JAL
  - lui -> LUI
  - else -> ILLEGAL
- MEMADR: alu_src_a=01, alu_src_b=01, alu_op=00. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read=1, address_source=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, result_source=01. Then FETCH.
- MEMWRITE: mem_write=1, address_source=1. Hold until mem_ready=1, then FETCH.
- EXECUTER: alu_src_a=01, alu_src_b=00, alu_op=10. Then ALUWB.
- EXECUTEI: alu_src_a=01, alu_src_b=01, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, result_source=00. Then FETCH.
- JAL: alu_src_a=10, alu_src_b=01, alu_op=00, pc_write=1, reg_write=1, result_source=10. Then FETCH.
- LUI: reg_write=1, result_source=11. Then FETCH.
- ILLEGAL: illegal_instr=1 for exactly one cycle, no register or memory write. Then FETCH.
- retired_count:
  - Increments by 1 on the clock edge leaving MEMWB, MEMWRITE (with mem_ready=1), ALUWB, JAL or LUI.
  - Wraps modulo 2^COUNT_WIDTH.
  - Never increments on ILLEGAL.
- mem_read and mem_write are never both 1.
- The IR changes only on an ir_write edge.
- If mem_ready is stuck at 0, the FSM holds its state indefinitely with its request held stable.
- Reset asserted mid-instruction (including mid memory wait) aborts immediately to IDLE. No partial write strobes follow reset release.

Test Plan:
- Reset, then release:
  - Cycle 0: IDLE with all strobes 0 and immediate_source=11.
  - Cycle 1: FETCH with mem_read=1.
  - full_instruction = 0x00000013.
- Fetch lw 0x00412083 with mem_ready=1 every cycle:
  - State sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - immediate_source goes 11 -> 00.
  - reg_write=1 only in MEMWB; retired_count goes 0 -> 1.
- sw 0x00112223 with mem_ready held 0 for 3 cycles in MEMWRITE:
  - mem_write stays 1 for 4 cycles.
  - immediate_source=01.
  - No retire until the mem_ready=1 edge.
- jal 0x008000EF, then lui 0x123450B7:
  - JAL state asserts pc_write=1 and reg_write=1 with immediate_source=10.
  - LUI has result_source=11.
  - immediate_source sequence is 11, 10, 11, 10.
- Opcode 0x0000007F:
  - DECODE -> ILLEGAL, illegal_instr pulses for 1 cycle.
  - No reg_write or mem_write; retired_count unchanged.
- Assert reset during a MEMREAD wait:
  - Outputs go to reset values immediately (asynchronously).
  - IR = 0x00000013, retired_count = 0.
